// File: rtl/pckg_parser.sv
// Packet parser for the LVDS receive path.
// Hunts for a sync'd header, buffers N payload words while folding them into a
// running XOR, verifies the checksum word, then replays the buffered payload
// on the channel named in the header, one word per clock.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   rx_ena, rx_data       one-cycle strobe qualifying a received DW-bit word
//   ch1_valid, ch1_data   released payload words for channel 1
//   ch2_valid, ch2_data   released payload words for channel 2
//   pkt_ok                one-cycle pulse when a packet's checksum matches
//   pkt_err               one-cycle pulse when a packet or word is dropped
//   err_code              cause of the last pkt_err (00 hdr, 01 csum, 10 timeout, 11 overrun)
//   err_cnt               saturating count of pkt_err pulses
//   busy                  high from header accept until the last released word
module pckg_parser #(
  parameter int unsigned DW      = 16,
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_ena,
  input  logic [DW-1:0] rx_data,
  output logic          ch1_valid,
  output logic [DW-1:0] ch1_data,
  output logic          ch2_valid,
  output logic [DW-1:0] ch2_data,
  output logic          pkt_ok,
  output logic          pkt_err,
  output logic [1:0]    err_code,
  output logic [7:0]    err_cnt,
  output logic          busy
);

  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0]    MAX_N     = 4'(MAX_LEN);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_HDR  = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            chan_q, chan_d;      // 0: channel 1, 1: channel 2
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [DW-1:0]   xor_q, xor_d;
  logic [TW-1:0]   idle_q, idle_d;

  logic            ch1_valid_d, ch2_valid_d;
  logic [DW-1:0]   ch1_data_d, ch2_data_d;
  logic            pkt_ok_d, pkt_err_d;
  logic [1:0]      err_code_d;
  logic [7:0]      err_cnt_d;
  logic            busy_d;

  logic            buf_we;
  logic            rel;
  logic [IW-1:0]   rel_idx;
  logic            err_hit;
  logic [1:0]      err_kind;
  logic            abort;

  logic [DW-1:0]   pbuf [MAX_LEN];

  logic [7:0]      hdr_sync;
  logic [3:0]      hdr_id;
  logic [3:0]      hdr_n;
  logic            hdr_good;

  // Header field decode; only meaningful while hunting.
  always_comb begin
    hdr_sync = rx_data[15:8];
    hdr_id   = rx_data[7:4];
    hdr_n    = rx_data[3:0];
    hdr_good = ((hdr_id == 4'h1) || (hdr_id == 4'h2)) &&
               (hdr_n != 4'h0) && (hdr_n <= MAX_N);
  end

  // Payload buffer: written in PAYLOAD, read during release; no reset needed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      pbuf[wr_idx_q] <= rx_data;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    xor_d       = xor_q;
    idle_d      = idle_q;
    ch1_valid_d = 1'b0;
    ch2_valid_d = 1'b0;
    ch1_data_d  = ch1_data;
    ch2_data_d  = ch2_data;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code;
    err_cnt_d   = err_cnt;
    busy_d      = busy;
    buf_we      = 1'b0;
    rel         = 1'b0;
    rel_idx     = '0;
    err_hit     = 1'b0;
    err_kind    = ERR_HDR;
    abort       = 1'b0;

    unique case (state_q)
      HUNT: begin
        // Words without the sync byte are line noise and dropped silently.
        if (rx_ena && (hdr_sync == SYNC)) begin
          if (hdr_good) begin
            chan_d   = (hdr_id == 4'h2);
            len_d    = IW'(hdr_n);
            xor_d    = rx_data;
            wr_idx_d = '0;
            idle_d   = '0;
            busy_d   = 1'b1;
            state_d  = PAYLOAD;
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_HDR;
          end
        end
      end

      PAYLOAD: begin
        if (rx_ena) begin
          buf_we   = 1'b1;
          xor_d    = xor_q ^ rx_data;
          wr_idx_d = IW'(wr_idx_q + IW'(1));
          idle_d   = '0;
          if (IW'(wr_idx_q + IW'(1)) == len_q) begin
            state_d = CHECK;
          end
        end else if (idle_q == IDLE_LAST) begin
          err_hit  = 1'b1;
          err_kind = ERR_TMO;
          abort    = 1'b1;
        end else begin
          idle_d = TW'(idle_q + TW'(1));
        end
      end

      CHECK: begin
        if (rx_ena) begin
          idle_d = '0;
          if (rx_data == xor_q) begin
            // Word 0 goes out in the same cycle pkt_ok is raised.
            pkt_ok_d = 1'b1;
            rel      = 1'b1;
            rel_idx  = '0;
            rd_idx_d = IW'(1);
            state_d  = DRAIN;
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_CSUM;
            abort    = 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          err_hit  = 1'b1;
          err_kind = ERR_TMO;
          abort    = 1'b1;
        end else begin
          idle_d = TW'(idle_q + TW'(1));
        end
      end

      DRAIN: begin
        // Incoming words cannot be accepted while replaying; flag and drop.
        if (rx_ena) begin
          err_hit  = 1'b1;
          err_kind = ERR_OVR;
        end
        if (rd_idx_q != len_q) begin
          rel      = 1'b1;
          rel_idx  = rd_idx_q;
          rd_idx_d = IW'(rd_idx_q + IW'(1));
        end else begin
          abort = 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    if (rel) begin
      if (chan_q) begin
        ch2_valid_d = 1'b1;
        ch2_data_d  = pbuf[rel_idx];
      end else begin
        ch1_valid_d = 1'b1;
        ch1_data_d  = pbuf[rel_idx];
      end
    end

    if (err_hit) begin
      pkt_err_d  = 1'b1;
      err_code_d = err_kind;
      if (err_cnt != 8'hFF) begin
        err_cnt_d = err_cnt + 8'd1;
      end
    end

    if (abort) begin
      state_d = HUNT;
      busy_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      chan_q    <= 1'b0;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      xor_q     <= '0;
      idle_q    <= '0;
      ch1_valid <= 1'b0;
      ch2_valid <= 1'b0;
      ch1_data  <= '0;
      ch2_data  <= '0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= 2'b00;
      err_cnt   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      xor_q     <= xor_d;
      idle_q    <= idle_d;
      ch1_valid <= ch1_valid_d;
      ch2_valid <= ch2_valid_d;
      ch1_data  <= ch1_data_d;
      ch2_data  <= ch2_data_d;
      pkt_ok    <= pkt_ok_d;
      pkt_err   <= pkt_err_d;
      err_code  <= err_code_d;
      err_cnt   <= err_cnt_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/pckg_parser.md
PCKG_PARSER -- requirements
Module: pckg_parser

Interface
REQ-001 Parameter DW, default 16: received word width, equal to CH_NUM*BUFF_SIZE.
REQ-002 Parameter MAX_LEN, default 15: maximum payload words per packet.
REQ-003 Parameter TIMEOUT, default 64: idle clocks allowed between words inside a packet.
REQ-004 Parameter SYNC, default 8'hA5: header sync byte.
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rx_ena  in  1  one-cycle strobe: rx_data holds a complete received word.
REQ-008 rx_data  in  DW  received word from the LVDS receiver.
REQ-009 ch1_valid / ch2_valid  out  1  one-cycle strobe per released payload word.
REQ-010 ch1_data / ch2_data  out  DW  released payload word, meaningful only while the matching valid is high.
REQ-011 pkt_ok  out  1  one-cycle pulse on a good packet.
REQ-012 pkt_err  out  1  one-cycle pulse on a dropped packet or word.
REQ-013 err_code  out  2  cause of the last pkt_err, held until the next error: 00 header, 01 checksum, 10 timeout, 11 overrun.
REQ-014 err_cnt  out  8  count of pkt_err pulses, saturating at 255.
REQ-015 busy  out  1  high from header accept until the last released word.

Function
REQ-016 Packet format SHALL be: header word, then N payload words, then checksum word.
REQ-017 Header fields SHALL be: [15:8]=SYNC, [7:4]=channel id (4'h1 or 4'h2), [3:0]=N (1..MAX_LEN).
REQ-018 Checksum SHALL be the bitwise XOR of the header and all N payload words.
REQ-019 The FSM SHALL have exactly four states: HUNT, PAYLOAD, CHECK, DRAIN.
REQ-020 HUNT: a word with [15:8]!=SYNC SHALL be ignored silently with no error.
REQ-021 HUNT: a word with sync OK but an invalid channel id or N=0 SHALL pulse pkt_err with code 00 and stay in HUNT.
REQ-022 HUNT: a valid header SHALL latch channel and N, seed the running XOR with the header, and go to PAYLOAD.
REQ-023 PAYLOAD: each rx_ena SHALL write the word to an internal MAX_LEN x DW buffer at the write index, fold it into the XOR, and increment the index.
REQ-024 PAYLOAD SHALL go to CHECK after the Nth payload word.
REQ-025 CHECK, rx_ena with rx_data==XOR: if the checksum is accepted in cycle k, then in cycle k+1 pkt_ok=1, the FSM enters DRAIN, and word 0 is released.
REQ-026 DRAIN SHALL release words 0..N-1 on the latched channel in cycles k+1..k+N, contiguous, one per cycle, with no output on the other channel.
REQ-027 CHECK, rx_ena with mismatch: pkt_err with code 01 in the next cycle, return to HUNT, nothing released.
REQ-028 Timeout: an idle counter SHALL clear on each accepted word in PAYLOAD/CHECK.
REQ-029 When the idle counter reaches TIMEOUT, the block SHALL pulse pkt_err with code 10 and go to HUNT, discarding the packet.
REQ-030 Overrun: rx_ena during DRAIN SHALL drop the word and pulse pkt_err with code 11; the drain SHALL complete unaffected, then go to HUNT.
REQ-031 The sync byte SHALL NOT be rechecked inside PAYLOAD/CHECK, so payload may contain SYNC.
REQ-032 pkt_ok and pkt_err SHALL never be high in the same cycle.
REQ-033 err_cnt SHALL increment exactly once per pkt_err pulse and hold at 255.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst_n low SHALL immediately put the FSM in HUNT and clear all valids, pkt_ok, pkt_err, busy, err_code, err_cnt, data outputs, indices, XOR and the idle counter, including mid-packet and mid-drain.
REQ-036 Buffer contents SHALL NOT require reset.
REQ-037 After rst_n rises, the first accepted word SHALL be treated as in HUNT.

Verification
REQ-038 Good packet: A512, 0001, 0002, checksum A511 -> pkt_ok one cycle after the checksum; ch1_valid for 2 cycles carrying 0001 then 0002; ch2_valid stays 0.
REQ-039 Bad checksum: A521, 1234, checksum 0000 -> pkt_err, err_code=01, err_cnt=1, no valids, FSM in HUNT.
REQ-040 Header check: 00FF then A530 -> first word ignored; second gives pkt_err, code 00.
REQ-041 Timeout: A513 then 2 payload words, then 64 idle clocks -> pkt_err, code 10, busy=0; the next valid packet is accepted normally.
REQ-042 Overrun: 15-word packet, with rx_ena asserted on the 3rd drain cycle -> all 15 words released; pkt_err, code 11.
REQ-043 Reset: assert rst_n mid-PAYLOAD -> outputs 0 immediately; a good packet after release passes.
REQ-044 Saturation: 300 bad headers -> err_cnt=255.
